// File: rtl/qar_timer_pkg.sv
// qar_timer_pkg: register word indices, CTRL/STATUS bit positions and bus FSM states
package qar_timer_pkg;

    localparam logic [2:0] OFF_CTRL     = 3'd0;
    localparam logic [2:0] OFF_STATUS   = 3'd1;
    localparam logic [2:0] OFF_PRESCALE = 3'd2;
    localparam logic [2:0] OFF_MTIME_LO = 3'd3;
    localparam logic [2:0] OFF_MTIME_HI = 3'd4;
    localparam logic [2:0] OFF_CMP_LO   = 3'd5;
    localparam logic [2:0] OFF_CMP_HI   = 3'd6;

    localparam int CTRL_EN        = 0;
    localparam int CTRL_IRQ_EN    = 1;
    localparam int CTRL_AUTO      = 2;
    localparam int STATUS_PENDING = 0;

    typedef enum logic {ST_IDLE, ST_RESP} bus_state_t;

endpackage

// File: rtl/qar_prescaler.sv
// qar_prescaler: free-running divider that ticks once every reload+1 enabled clocks
module qar_prescaler #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] reload,
    output logic             tick
);

    logic [WIDTH-1:0] cnt;

    assign tick = en && !clr && (cnt == reload);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else
            cnt <= (!en || clr || cnt == reload) ? '0 : cnt + 1'b1;
    end

endmodule

// File: rtl/qar_timer.sv
// qar_timer: memory-mapped 64-bit machine timer with compare interrupt
module qar_timer
    import qar_timer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0400,
    parameter int          PRESCALE_WIDTH = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_valid,
    input  logic        mem_we,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic        irq_timer,
    input  logic        irq_timer_ack
);

    bus_state_t                state, state_nx;
    logic                      hit, accept, wr, rd;
    logic [2:0]                idx;
    logic [2:0]                ctrl, ctrl_nx;
    logic                      pending, pending_nx, irq_q;
    logic [PRESCALE_WIDTH-1:0] prescale;
    logic [63:0]               mtime, mtime_nx, cmp;
    logic [31:0]               shadow, rdata_q, rd_val;
    logic                      tick, match;
    logic                      unused;

    assign unused = &{1'b0, mem_addr[1:0]};

    assign hit    = mem_valid && (mem_addr[31:5] == BASE_ADDR[31:5]);
    assign accept = (state == ST_IDLE) && hit;
    assign wr     = accept && mem_we;
    assign rd     = accept && !mem_we;
    assign idx    = mem_addr[4:2];

    always_comb state_nx = (state == ST_IDLE && hit) ? ST_RESP : ST_IDLE;

    assign mem_ready = (state == ST_RESP);
    assign mem_rdata = mem_ready ? rdata_q : '0;
    assign irq_timer = irq_q;

    always_comb begin
        rd_val = '0;
        case (idx)
            OFF_CTRL:     rd_val[2:0] = ctrl;
            OFF_STATUS:   rd_val[STATUS_PENDING] = pending;
            OFF_PRESCALE: rd_val[PRESCALE_WIDTH-1:0] = prescale;
            OFF_MTIME_LO: rd_val = mtime[31:0];
            OFF_MTIME_HI: rd_val = shadow;
            OFF_CMP_LO:   rd_val = cmp[31:0];
            OFF_CMP_HI:   rd_val = cmp[63:32];
            default:      rd_val = '0;
        endcase
    end

    qar_prescaler #(.WIDTH(PRESCALE_WIDTH)) u_prescaler (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (ctrl[CTRL_EN]),
        .clr    (wr && idx == OFF_PRESCALE),
        .reload (prescale),
        .tick   (tick)
    );

    assign match   = ctrl[CTRL_EN] && (mtime >= cmp);
    assign ctrl_nx = (wr && idx == OFF_CTRL) ? mem_wdata[2:0] : ctrl;
    // Setting wins over ack and W1C so a live match is never lost.
    assign pending_nx = match ||
        (pending && !(irq_timer_ack || (wr && idx == OFF_STATUS && mem_wdata[STATUS_PENDING])));

    always_comb begin
        mtime_nx = mtime;
        if (wr && idx == OFF_MTIME_LO)
            mtime_nx[31:0] = mem_wdata;
        else if (wr && idx == OFF_MTIME_HI)
            mtime_nx[63:32] = mem_wdata;
        else if (tick)
            mtime_nx = (ctrl[CTRL_AUTO] && match) ? 64'd0 : mtime + 64'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            ctrl     <= '0;
            pending  <= 1'b0;
            irq_q    <= 1'b0;
            prescale <= '0;
            mtime    <= '0;
            cmp      <= '0;
            shadow   <= '0;
            rdata_q  <= '0;
        end else begin
            state   <= state_nx;
            ctrl    <= ctrl_nx;
            pending <= pending_nx;
            irq_q   <= pending_nx && ctrl_nx[CTRL_IRQ_EN];
            mtime   <= mtime_nx;
            if (wr && idx == OFF_PRESCALE)
                prescale <= mem_wdata[PRESCALE_WIDTH-1:0];
            if (wr && idx == OFF_CMP_LO)
                cmp[31:0] <= mem_wdata;
            if (wr && idx == OFF_CMP_HI)
                cmp[63:32] <= mem_wdata;
            if (rd && idx == OFF_MTIME_LO)
                shadow <= mtime[63:32];
            if (accept)
                rdata_q <= mem_we ? '0 : rd_val;
        end
    end

endmodule

// File: tb/tb_qar_timer.sv
// tb_qar_timer: directed register table plus hand-timed sequences for the timer
module tb_qar_timer;

    localparam logic [31:0] BASE = 32'h0000_0400;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_valid = 1'b0;
    logic        mem_we = 1'b0;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_wdata = '0;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        irq_timer;
    logic        irq_timer_ack = 1'b0;

    int checks = 0;
    int errors = 0;

    qar_timer #(.BASE_ADDR(BASE), .PRESCALE_WIDTH(16)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .mem_valid     (mem_valid),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_ready     (mem_ready),
        .mem_rdata     (mem_rdata),
        .irq_timer     (irq_timer),
        .irq_timer_ack (irq_timer_ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [4:0]  off;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[18];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic bus(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                       output logic [31:0] rd, output int lat);
        bit got = 0;
        @(posedge clk);
        #1;
        mem_valid = 1'b1;
        mem_we    = we;
        mem_addr  = addr;
        mem_wdata = wd;
        lat = 0;
        rd  = '0;
        while (!got && lat < 8) begin
            @(negedge clk);
            lat++;
            if (mem_ready) begin
                got = 1;
                rd  = mem_rdata;
            end
        end
        mem_valid = 1'b0;
        mem_we    = 1'b0;
        if (!got) lat = -1;
    endtask

    task automatic wr(input logic [4:0] off, input logic [31:0] d);
        logic [31:0] r;
        int lat;
        bus(1'b1, BASE + 32'(off), d, r, lat);
        chk("wr_latency", 64'(lat), 64'd2);
    endtask

    task automatic rd_chk(input string nm, input logic [4:0] off, input logic [31:0] exp);
        logic [31:0] r;
        int lat;
        bus(1'b0, BASE + 32'(off), 32'h0, r, lat);
        chk("rd_latency", 64'(lat), 64'd2);
        chk(nm, 64'(r), 64'(exp));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        mem_valid = 1'b0;
        irq_timer_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 64'(mem_ready), 64'd0);
        chk("rst_rdata", 64'(mem_rdata), 64'd0);
        chk("rst_irq", 64'(irq_timer), 64'd0);
        rst_n = 1'b1;
    endtask

    task automatic ack_pulse();
        @(negedge clk);
        irq_timer_ack = 1'b1;
        @(negedge clk);
        irq_timer_ack = 1'b0;
    endtask

    initial begin
        int n;
        int lat;
        logic [31:0] r;

        tbl[0]  = '{1'b1, 5'h00, 32'hFFFF_FFFC, 32'h0};
        tbl[1]  = '{1'b0, 5'h00, 32'h0,         32'h4};
        tbl[2]  = '{1'b1, 5'h08, 32'hFFFF_1234, 32'h0};
        tbl[3]  = '{1'b0, 5'h08, 32'h0,         32'h0000_1234};
        tbl[4]  = '{1'b1, 5'h14, 32'hA5A5_A5A5, 32'h0};
        tbl[5]  = '{1'b1, 5'h18, 32'h5A5A_5A5A, 32'h0};
        tbl[6]  = '{1'b0, 5'h14, 32'h0,         32'hA5A5_A5A5};
        tbl[7]  = '{1'b0, 5'h18, 32'h0,         32'h5A5A_5A5A};
        tbl[8]  = '{1'b1, 5'h0C, 32'hDEAD_BEEF, 32'h0};
        tbl[9]  = '{1'b1, 5'h10, 32'h1234_5678, 32'h0};
        tbl[10] = '{1'b0, 5'h0C, 32'h0,         32'hDEAD_BEEF};
        tbl[11] = '{1'b0, 5'h10, 32'h0,         32'h1234_5678};
        tbl[12] = '{1'b1, 5'h1C, 32'hFFFF_FFFF, 32'h0};
        tbl[13] = '{1'b0, 5'h1C, 32'h0,         32'h0};
        tbl[14] = '{1'b0, 5'h00, 32'h0,         32'h4};
        tbl[15] = '{1'b0, 5'h04, 32'h0,         32'h0};
        tbl[16] = '{1'b1, 5'h00, 32'h0,         32'h0};
        tbl[17] = '{1'b0, 5'h00, 32'h0,         32'h0};

        // reset state and first read
        do_reset();
        rd_chk("ctrl_after_reset", 5'h00, 32'h0);
        chk("irq_after_reset", 64'(irq_timer), 64'd0);
        @(negedge clk);
        chk("ready_one_cycle", 64'(mem_ready), 64'd0);

        // register table with the timer stopped
        for (int i = 0; i < 18; i++) begin
            if (tbl[i].we)
                wr(tbl[i].off, tbl[i].wdata);
            else
                rd_chk($sformatf("tbl%0d", i), tbl[i].off, tbl[i].exp);
        end

        // compare interrupt: PRESCALE=3, CMP=10, irq 41 clocks after the EN edge
        do_reset();
        wr(5'h08, 32'd3);
        wr(5'h14, 32'd10);
        wr(5'h00, 32'b011);
        n = 0;
        while (!irq_timer && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("irq_rise_clocks", 64'(n), 64'd41);
        rd_chk("status_pending", 5'h04, 32'h1);

        // ack while still matching keeps PENDING
        ack_pulse();
        chk("ack_while_match_irq", 64'(irq_timer), 64'd1);
        wr(5'h18, 32'h1);
        chk("cmp_raise_keeps_irq", 64'(irq_timer), 64'd1);
        @(negedge clk);
        irq_timer_ack = 1'b1;
        @(negedge clk);
        irq_timer_ack = 1'b0;
        chk("ack_clears_irq", 64'(irq_timer), 64'd0);
        rd_chk("status_after_ack", 5'h04, 32'h0);
        wr(5'h18, 32'h0);
        wr(5'h04, 32'h1);
        rd_chk("w1c_loses_to_set", 5'h04, 32'h1);
        wr(5'h18, 32'h1);
        wr(5'h04, 32'h1);
        rd_chk("w1c_clears", 5'h04, 32'h0);

        // auto-reload: PRESCALE=0, CMP=5 -> period of 6 clocks
        do_reset();
        wr(5'h14, 32'd5);
        wr(5'h00, 32'b111);
        n = 0;
        while (!irq_timer && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("auto_first_irq", 64'(n), 64'd6);
        for (int p = 0; p < 2; p++) begin
            irq_timer_ack = 1'b1;
            @(negedge clk);
            irq_timer_ack = 1'b0;
            n = 1;
            chk("auto_ack_clears", 64'(irq_timer), 64'd0);
            while (!irq_timer && n < 50) begin
                @(negedge clk);
                n++;
            end
            chk("auto_period", 64'(n), 64'd6);
        end

        // MTIME_HI returns the snapshot taken by the MTIME_LO read
        do_reset();
        wr(5'h0C, 32'hFFFF_FFFF);
        rd_chk("mtime_lo_max", 5'h0C, 32'hFFFF_FFFF);
        wr(5'h00, 32'h1);
        rd_chk("mtime_hi_snapshot", 5'h10, 32'h0);
        bus(1'b0, BASE + 32'h0C, 32'h0, r, lat);
        rd_chk("mtime_hi_resnap", 5'h10, 32'h1);
        chk("irq_masked", 64'(irq_timer), 64'd0);

        // outside the window: no ready, no state change
        do_reset();
        @(posedge clk);
        #1;
        mem_valid = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = BASE + 32'h20;
        mem_wdata = 32'h7;
        n = 0;
        repeat (6) begin
            @(negedge clk);
            if (mem_ready) n++;
        end
        mem_valid = 1'b0;
        mem_we    = 1'b0;
        chk("miss_no_ready", 64'(n), 64'd0);
        rd_chk("miss_no_write", 5'h00, 32'h0);

        // reset asserted during RESP aborts the access
        wr(5'h00, 32'h4);
        @(posedge clk);
        #1;
        mem_valid = 1'b1;
        mem_addr  = BASE;
        @(negedge clk);
        @(negedge clk);
        chk("resp_before_reset", 64'(mem_ready), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("reset_kills_ready", 64'(mem_ready), 64'd0);
        chk("reset_kills_rdata", 64'(mem_rdata), 64'd0);
        mem_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        n = 0;
        repeat (5) begin
            @(negedge clk);
            if (mem_ready) n++;
        end
        chk("no_ready_after_reset", 64'(n), 64'd0);
        rd_chk("ctrl_cleared", 5'h00, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
